iomem_arbiter: RTL and testbench
================================

IOMEM_ARBITER -- requirements
Module: iomem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: BUSY cycles without iomem_ready before abort; legal range 1..65535.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 m0_valid / m1_valid  input  1  requester 0/1 transfer request; held until its ready.
REQ-005 m0_wstrb / m1_wstrb  input  4  byte write strobes; 4'b0000 = read.
REQ-006 m0_addr / m1_addr  input  32  byte address.
REQ-007 m0_wdata / m1_wdata  input  32  write data.
REQ-008 m0_ready / m1_ready  output  1  one-cycle completion pulse to requester.
REQ-009 m0_rdata / m1_rdata  output  32  read data, valid while matching ready is high.
REQ-010 iomem_valid  output  1  shared bus request.
REQ-011 iomem_ready  input  1  shared bus completion.
REQ-012 iomem_wstrb / iomem_addr / iomem_wdata  output  4/32/32  shared bus command.
REQ-013 iomem_rdata  input  32  shared bus read data.
REQ-014 timeout  output  1  one-cycle pulse when a transfer is aborted.

Function
REQ-015 The block SHALL share one iomem bus between two requesters, one outstanding transfer at a time, with registered outputs only.
REQ-016 States SHALL be IDLE, BUSY, RESP.
REQ-017 IDLE: any mX_valid high -> latch grant, wstrb, addr, wdata of selected requester; go BUSY next edge.
REQ-018 Both valid in IDLE: grant requester not served last (round-robin); one valid -> grant it regardless of pointer.
REQ-019 The round-robin pointer SHALL update only on entry to RESP.
REQ-020 BUSY: iomem_valid=1 with latched command, stable for the whole state; first BUSY cycle is one cycle after request sampled in IDLE.
REQ-021 BUSY and iomem_ready=1: capture iomem_rdata into granted mX_rdata, go RESP; iomem_valid low in RESP.
REQ-022 BUSY cycle counter SHALL start at 0 on BUSY entry; when it reaches TIMEOUT_CYCLES-1 without iomem_ready: go RESP with mX_rdata=32'hFFFF_FFFF, timeout pulsed high in RESP.
REQ-023 iomem_ready in the same cycle the counter hits TIMEOUT_CYCLES-1 SHALL complete normally, no timeout.
REQ-024 RESP: granted mX_ready=1 for exactly one cycle, other mX_ready=0; unconditional return to IDLE.
REQ-025 A request held valid through RESP SHALL NOT be re-granted from RESP; requesters drop valid after ready.
REQ-026 Ungranted requester's valid and command SHALL be ignored until granted; its ready stays 0.
REQ-027 iomem_ready outside BUSY SHALL be ignored.
REQ-028 mX_rdata SHALL hold last captured value until next completion for that requester.

Reset
REQ-029 reset=1 at a clock edge SHALL force IDLE, counter 0, pointer favoring m0 next.
REQ-030 After reset: iomem_valid=0, iomem_wstrb=0, iomem_addr=0, iomem_wdata=0, m0_ready=m1_ready=0, m0_rdata=m1_rdata=0, timeout=0.
REQ-031 Reset during BUSY or RESP SHALL abandon the transfer without any ready or timeout pulse.

Verification
REQ-032 Single read: m0_valid, addr 0x0300_0004, wstrb 0; iomem_ready after 3 BUSY cycles with rdata 0x1234_5678 -> iomem_valid high 3 cycles, m0_ready one cycle later with m0_rdata 0x1234_5678.
REQ-033 Contention: m0 and m1 valid together from reset -> m0 served first, then m1; repeat -> m1 first on the third grant only if m1 was not last served (alternation verified over 4 grants).
REQ-034 Write: m1 wstrb 4'b0011, wdata 0xCAFE_F00D -> iomem_wstrb/wdata match throughout BUSY, m1_ready single pulse.
REQ-035 Timeout: TIMEOUT_CYCLES=8, iomem_ready never asserted -> iomem_valid high exactly 8 cycles, then m0_ready and timeout together, m0_rdata 0xFFFF_FFFF.
REQ-036 Boundary: TIMEOUT_CYCLES=8, iomem_ready on 8th BUSY cycle -> normal completion, timeout stays 0.
REQ-037 Reset mid-BUSY: reset asserted on 2nd BUSY cycle -> next cycle all outputs per REQ-030, no ready pulse.

Source files
------------

// File: rtl/iomem_arbiter.sv
// iomem_arbiter: shares one iomem bus between two requesters, one transfer
// at a time. Round-robin grant when both request together; BUSY watchdog
// aborts a stalled transfer with all-ones read data and a timeout pulse.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no transfer; sample m0_valid/m1_valid and latch a grant
// BUSY   | iomem_valid driven with latched command; wait ready/watchdog
// RESP   | one-cycle ready pulse to granted requester; back to IDLE
module iomem_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_valid,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        iomem_valid,
    input  logic        iomem_ready,
    output logic [3:0]  iomem_wstrb,
    output logic [31:0] iomem_addr,
    output logic [31:0] iomem_wdata,
    input  logic [31:0] iomem_rdata,

    output logic        timeout
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // BUSY cycle index at which the watchdog gives up (counter starts at 0).
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    localparam logic [31:0] ABORT_DATA = 32'hFFFF_FFFF;

    logic [1:0]  state;
    logic [15:0] cnt;
    logic        grant;       // 1 = m1 owns the current transfer
    logic        last_grant;  // 1 = m1 was served last
    logic        pick1;

    // Grant m1 when it is the only requester, or when both request and m0
    // was the one served last.
    always_comb begin
        pick1 = m1_valid && (!m0_valid || !last_grant);
    end

    // Arbitration FSM with registered bus command, responses and watchdog.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= 16'd0;
            grant       <= 1'b0;
            last_grant  <= 1'b1;
            iomem_valid <= 1'b0;
            iomem_wstrb <= 4'd0;
            iomem_addr  <= 32'd0;
            iomem_wdata <= 32'd0;
            m0_ready    <= 1'b0;
            m1_ready    <= 1'b0;
            m0_rdata    <= 32'd0;
            m1_rdata    <= 32'd0;
            timeout     <= 1'b0;
        end else begin
            m0_ready <= 1'b0;
            m1_ready <= 1'b0;
            timeout  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (m0_valid || m1_valid) begin
                        grant       <= pick1;
                        iomem_wstrb <= pick1 ? m1_wstrb : m0_wstrb;
                        iomem_addr  <= pick1 ? m1_addr  : m0_addr;
                        iomem_wdata <= pick1 ? m1_wdata : m0_wdata;
                        iomem_valid <= 1'b1;
                        cnt         <= 16'd0;
                        state       <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // A ready on the watchdog's last cycle still wins.
                    if (iomem_ready || (cnt == CNT_LAST)) begin
                        iomem_valid <= 1'b0;
                        last_grant  <= grant;
                        timeout     <= !iomem_ready;
                        state       <= S_RESP;
                        if (grant) begin
                            m1_ready <= 1'b1;
                            m1_rdata <= iomem_ready ? iomem_rdata : ABORT_DATA;
                        end else begin
                            m0_ready <= 1'b1;
                            m0_rdata <= iomem_ready ? iomem_rdata : ABORT_DATA;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_RESP: begin
                    // Requesters still holding valid here are not re-granted;
                    // they drop valid after seeing ready.
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iomem_arbiter.sv
// Scoreboard bench for iomem_arbiter: random requests and slave latencies,
// expected completions queued in grant order by a round-robin model.
module tb_iomem_arbiter;

    localparam int T = 8;

    typedef struct {
        bit          id;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;   // BUSY cycle on which slave answers; > T = never
    } txn_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_valid, m1_valid;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        iomem_valid, iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr, iomem_wdata, iomem_rdata;
    logic        timeout;

    int vectors = 0;
    int miscompares = 0;

    txn_t        exp_q[$];
    txn_t        slave_q[$];
    bit          last_m1;
    logic [31:0] rd_model[2];

    always #5 clk = ~clk;

    iomem_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_wstrb(m0_wstrb), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
        .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
        .timeout(timeout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_iomem_valid"}, 32'(iomem_valid), 32'd0);
        chk({tag, "_iomem_wstrb"}, 32'(iomem_wstrb), 32'd0);
        chk({tag, "_iomem_addr"}, iomem_addr, 32'd0);
        chk({tag, "_iomem_wdata"}, iomem_wdata, 32'd0);
        chk({tag, "_m0_ready"}, 32'(m0_ready), 32'd0);
        chk({tag, "_m1_ready"}, 32'(m1_ready), 32'd0);
        chk({tag, "_m0_rdata"}, m0_rdata, 32'd0);
        chk({tag, "_m1_rdata"}, m1_rdata, 32'd0);
        chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    endtask

    function automatic txn_t rand_txn(input bit id);
        txn_t t;
        t.id    = id;
        t.wstrb = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
        t.addr  = $urandom;
        t.wdata = $urandom;
        t.rdata = $urandom;
        t.lat   = $urandom_range(1, T + 2);
        return t;
    endfunction

    // Issue one round (pat bit0 = m0, bit1 = m1); expected order follows
    // the round-robin rule, then wait until every requester is served.
    task automatic run_round(input int pat, input txn_t a0, input txn_t a1);
        int n;
        m0_wstrb = a0.wstrb; m0_addr = a0.addr; m0_wdata = a0.wdata;
        m1_wstrb = a1.wstrb; m1_addr = a1.addr; m1_wdata = a1.wdata;
        if (pat == 1) begin
            exp_q.push_back(a0); slave_q.push_back(a0); last_m1 = 1'b0;
        end else if (pat == 2) begin
            exp_q.push_back(a1); slave_q.push_back(a1); last_m1 = 1'b1;
        end else if (last_m1) begin
            exp_q.push_back(a0); slave_q.push_back(a0);
            exp_q.push_back(a1); slave_q.push_back(a1); last_m1 = 1'b1;
        end else begin
            exp_q.push_back(a1); slave_q.push_back(a1);
            exp_q.push_back(a0); slave_q.push_back(a0); last_m1 = 1'b0;
        end
        m0_valid = pat[0];
        m1_valid = pat[1];
        n = 0;
        while ((m0_valid || m1_valid) && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (m0_ready) m0_valid = 1'b0;
            if (m1_ready) m1_valid = 1'b0;
        end
        if (n >= 200) begin
            vectors++;
            miscompares++;
            $display("FAIL round_wait: got no ready within %0d cycles expected completion", n);
            m0_valid = 1'b0;
            m1_valid = 1'b0;
        end
    endtask

    // Slave model: answers on the txn's chosen BUSY cycle; toggles ready
    // randomly while the bus is idle, which the DUT must ignore.
    initial begin
        int   k;
        bit   active;
        txn_t cur;
        iomem_ready = 1'b0;
        iomem_rdata = 32'd0;
        active = 1'b0;
        k = 0;
        cur.lat = 0;
        cur.rdata = 32'd0;
        forever begin
            @(posedge clk); #1;
            if (iomem_valid) begin
                if (!active) begin
                    active = 1'b1;
                    k = 0;
                    if (slave_q.size() > 0) cur = slave_q.pop_front();
                    else cur.lat = 0;
                end
                k++;
                if (cur.lat == k) begin
                    iomem_ready = 1'b1;
                    iomem_rdata = cur.rdata;
                end else begin
                    iomem_ready = 1'b0;
                    iomem_rdata = $urandom;
                end
            end else begin
                active = 1'b0;
                iomem_ready = 1'($urandom_range(0, 1));
                iomem_rdata = $urandom;
            end
        end
    end

    // Monitor: checks bus command during BUSY and each completion against
    // the scoreboard head.
    initial begin
        int   bc;
        bit   exp_to;
        txn_t e;
        bc = 0;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                bc = 0;
            end else begin
                if (iomem_valid) begin
                    bc++;
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL bus_unexpected: got iomem_valid=1 expected 0");
                    end else begin
                        e = exp_q[0];
                        chk("bus_wstrb", 32'(iomem_wstrb), 32'(e.wstrb));
                        chk("bus_addr", iomem_addr, e.addr);
                        chk("bus_wdata", iomem_wdata, e.wdata);
                    end
                end
                if (m0_ready || m1_ready || timeout) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL ready_unexpected: got m0_ready=%0b m1_ready=%0b timeout=%0b expected none",
                                 m0_ready, m1_ready, timeout);
                    end else begin
                        e = exp_q.pop_front();
                        exp_to = (e.lat > T);
                        rd_model[e.id] = exp_to ? 32'hFFFF_FFFF : e.rdata;
                        chk("ready_vec", 32'({m1_ready, m0_ready}), e.id ? 32'd2 : 32'd1);
                        chk("timeout", 32'(timeout), 32'(exp_to));
                        chk("m0_rdata", m0_rdata, rd_model[0]);
                        chk("m1_rdata", m1_rdata, rd_model[1]);
                        chk("busy_len", 32'(bc), exp_to ? 32'(T) : 32'(e.lat));
                    end
                    bc = 0;
                end
            end
        end
    end

    initial begin
        txn_t a0, a1;
        int   n;
        reset = 1'b1;
        m0_valid = 1'b0; m1_valid = 1'b0;
        m0_wstrb = 4'd0; m1_wstrb = 4'd0;
        m0_addr = 32'd0; m1_addr = 32'd0;
        m0_wdata = 32'd0; m1_wdata = 32'd0;
        last_m1 = 1'b1;
        rd_model[0] = 32'd0;
        rd_model[1] = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // Contention from reset: m0, m1, m0, m1.
        for (int r = 0; r < 2; r++) begin
            run_round(3, rand_txn(1'b0), rand_txn(1'b1));
        end

        // Single read answered on the 3rd BUSY cycle.
        a0 = rand_txn(1'b0);
        a0.wstrb = 4'd0; a0.addr = 32'h0300_0004; a0.rdata = 32'h1234_5678; a0.lat = 3;
        run_round(1, a0, rand_txn(1'b1));

        // Write from m1.
        a1 = rand_txn(1'b1);
        a1.wstrb = 4'b0011; a1.wdata = 32'hCAFE_F00D; a1.lat = 2;
        run_round(2, rand_txn(1'b0), a1);

        // Timeout: slave never answers.
        a0 = rand_txn(1'b0);
        a0.lat = T + 1;
        run_round(1, a0, rand_txn(1'b1));

        // Boundary: answer on the last watchdog cycle.
        a1 = rand_txn(1'b1);
        a1.lat = T;
        run_round(2, rand_txn(1'b0), a1);

        for (int r = 0; r < 60; r++) begin
            run_round($urandom_range(1, 3), rand_txn(1'b0), rand_txn(1'b1));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        // Reset on the 2nd BUSY cycle abandons the transfer.
        a0 = rand_txn(1'b0);
        a0.lat = 100;
        m0_wstrb = a0.wstrb; m0_addr = a0.addr; m0_wdata = a0.wdata;
        exp_q.push_back(a0);
        slave_q.push_back(a0);
        m0_valid = 1'b1;
        n = 0;
        while (!iomem_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rst_busy_reached", 32'(iomem_valid), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        m0_valid = 1'b0;
        @(posedge clk); #1;
        chk_reset_outputs("rst_busy");
        exp_q.delete();
        slave_q.delete();
        rd_model[0] = 32'd0;
        rd_model[1] = 32'd0;
        last_m1 = 1'b1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        for (int r = 0; r < 6; r++) begin
            run_round($urandom_range(1, 3), rand_txn(1'b0), rand_txn(1'b1));
        end

        repeat (5) @(posedge clk);
        #1;
        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
